// File: rtl/wb_resp_queue.sv
// Wishbone B4 pipelined responder: word-addressed memory behind an in-order
// response queue with a minimum response latency and DV stall/hold injection.
module wb_resp_queue #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          DEPTH      = 4,
    parameter int          LATENCY    = 2
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    input  logic [31:0]                wb_adr_i,
    input  logic [DATA_WIDTH-1:0]      wb_dat_i,
    input  logic [3:0]                 wb_sel_i,
    output logic                       wb_stall_o,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    output logic [DATA_WIDTH-1:0]      wb_dat_o,
    input  logic                       stall_inj_i,
    input  logic                       hold_inj_i,
    output logic [$clog2(DEPTH):0]     pending_o
);
    localparam int          PW    = $clog2(DEPTH);
    localparam int          CW    = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [7:0]  LAT8  = 8'(LATENCY);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    logic [DATA_WIDTH-1:0] r_q_dat [DEPTH];
    logic                  r_q_err [DEPTH];
    logic [7:0]            r_q_ts  [DEPTH];
    logic [PW-1:0]         r_wp;
    logic [PW-1:0]         r_rp;
    logic [CW-1:0]         r_count;
    logic [7:0]            r_now;
    logic                  r_ack;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_dat;

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_in_range;
    logic [32:0]           w_diff;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [7:0]            w_head_age;
    logic                  w_unused_s;

    // A borrow out of the 33-bit difference means the address is below the window.
    assign w_diff     = {1'b0, wb_adr_i} - {1'b0, BASE_ADDR};
    assign w_in_range = !w_diff[32] && (w_diff[31:ADDR_WIDTH+2] == '0);
    assign w_idx      = w_diff[ADDR_WIDTH+1:2];
    assign w_unused_s = ^w_diff[1:0];
    assign w_rd_word  = mem[w_idx];

    assign wb_stall_o = (r_count == FULL) | stall_inj_i;
    assign w_accept   = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign w_head_age = r_now - r_q_ts[r_rp];
    assign w_pop      = wb_cyc_i & (r_count != '0) & (w_head_age >= LAT8) & ~hold_inj_i;

    assign wb_ack_o  = r_ack;
    assign wb_err_o  = r_err;
    assign wb_dat_o  = r_dat;
    assign pending_o = r_count;

    // Memory write port: byte-lane commit at the accept edge, never reset.
    always_ff @(posedge wb_clk_i) begin
        if (w_accept && wb_we_i && w_in_range && !wb_rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    mem[w_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    // Queue entry storage; validity is tracked by the pointers and count.
    always_ff @(posedge wb_clk_i) begin
        if (w_accept && wb_cyc_i && !wb_rst_i) begin
            r_q_dat[r_wp] <= (w_in_range && !wb_we_i) ? w_rd_word : '0;
            r_q_err[r_wp] <= !w_in_range;
            r_q_ts[r_wp]  <= r_now;
        end
    end

    // Queue control, timestamp counter and registered response outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_now   <= 8'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else if (!wb_cyc_i) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_now   <= r_now + 8'd1;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_now   <= r_now + 8'd1;
            r_count <= r_count + CW'(w_accept) - CW'(w_pop);
            if (w_accept) begin
                r_wp <= r_wp + PW'(1);
            end else begin
                r_wp <= r_wp;
            end
            if (w_pop) begin
                r_rp  <= r_rp + PW'(1);
                r_ack <= !r_q_err[r_rp];
                r_err <= r_q_err[r_rp];
                r_dat <= r_q_dat[r_rp];
            end else begin
                r_rp  <= r_rp;
                r_ack <= 1'b0;
                r_err <= 1'b0;
                r_dat <= '0;
            end
        end
    end
endmodule

// File: doc/wb_resp_queue.md
# wb_resp_queue

Wishbone B4 pipelined responder (slave) with a word-addressed memory, an in-order response queue, a fixed minimum response latency and injectable request stall/response hold. It is the far end of the core's instruction/data Wishbone adapters in DV benches. It exercises adapter back-pressure, multiple outstanding requests and error paths, which a zero-wait memory model never produces.

## Interface
- DATA_WIDTH, 32: data bus width (fixed 32; four byte lanes)
- ADDR_WIDTH, 14: memory word-index width (2^ADDR_WIDTH words)
- BASE_ADDR, 32'h0000_0000: byte base address of the memory window
- DEPTH, 4: response-queue entries (power of 2, 2..16)
- LATENCY, 2: clock edges from request acceptance to response assertion (1..127)

- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  request strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  32  byte address; bits [1:0] ignored
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte-lane enables, bit n = bits [8n+7:8n]
- wb_stall_o  out  1  request not accepted this cycle
- wb_ack_o  out  1  normal response, one cycle per request
- wb_err_o  out  1  error response, one cycle per request
- wb_dat_o  out  32  read data, valid with wb_ack_o on reads
- stall_inj_i  in  1  force wb_stall_o high (DV stall injection)
- hold_inj_i  in  1  block response issue this cycle (DV hold injection)
- pending_o  out  $clog2(DEPTH)+1  queued responses not yet issued

## Operation
- Accept: cyc & stb & !wb_stall_o at a rising edge. One accept per edge.
- wb_stall_o = (count == DEPTH) | stall_inj_i. Combinational; no credit for a same-cycle pop.
- Range check at accept: in range iff BASE_ADDR <= adr < BASE_ADDR + 4*2^ADDR_WIDTH (unsigned). Index = (adr - BASE_ADDR)[ADDR_WIDTH+1:2].
- In-range write: commit to array `mem` at the accept edge, sel lanes only. Queue entry type ACK, data 0.
- In-range read: capture array word at the accept edge (post any earlier write; read-after-write correct). Queue entry type ACK, data = word.
- Out-of-range: no array access. Queue entry type ERR, data 0.
- sel = 0 write: accepted and acked, no array change.
- Each entry stores a timestamp from a free-running 8-bit counter `now`. Eligible when (now - ts) mod 256 >= LATENCY.
- Issue: at an edge with cyc_i high, queue non-empty, head eligible and hold_inj_i low, pop head. Register ack_o or err_o high for exactly one cycle, with dat_o. Otherwise ack_o = err_o = 0 and dat_o = 0.
- Responses strictly in acceptance order; ack_o and err_o never both high.
- Push and pop on the same edge: count unchanged.
- cyc_i low at an edge: flush queue (count -> 0), no response issued. Committed writes remain; no accept that edge.
- Array is not reset (preloadable via $readmemh on `mem`). Contents survive wb_rst_i.

## Timing
- Reset (wb_rst_i high at an edge): wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0, pending_o = 0, queue empty, now = 0.
- wb_stall_o during reset = stall_inj_i.
- Reset mid-transaction: all queued responses are dropped. Writes accepted before the reset edge stay committed.
- Request accepted at edge k with no hold/backlog: response registered at edge k+LATENCY, high until edge k+LATENCY+1.
- Back-to-back accepts (no hold): one response per cycle, spaced like the accepts.
- Throughput 1/cycle when LATENCY < DEPTH. Otherwise stalls throttle it to DEPTH per LATENCY+1 cycles.
- pending_o registered; reflects count after each edge.

## Test plan
- Write 0xDEADBEEF to BASE+0x10 (sel=F), then read it; LATENCY=2 -> ack 2 edges after each accept; read dat_o = 0xDEADBEEF.
- Partial write: preload word 0x11223344, write 0xAABBCCDD sel=0101 -> readback 0x11BB33DD.
- DEPTH=4, LATENCY=8, stb held high for 8 reads: stall rises after 4 accepts; all 8 acks in order, no data loss; pending_o peaks at 4.
- hold_inj_i high 5 cycles with 3 pending: no ack during hold; 3 consecutive acks after release; stall_inj_i high blocks accepts with pending_o unchanged.
- Read BASE + 4*2^ADDR_WIDTH -> err_o one cycle, ack_o 0. Out-of-range write -> err, memory unchanged.
- Drop cyc_i with 3 pending -> pending_o = 0, no ack/err. Assert wb_rst_i with 2 pending -> outputs 0, earlier write still reads back.
